// File: rtl/queue_pkg.sv
// queue_pkg: shared sizing and occupancy types for the RAM-backed queue controller
package queue_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;
  localparam int DEPTH_DEF = 1 << AW_DEF;
  typedef logic [AW_DEF:0] occ_t;
  typedef logic [1:0] ob_cnt_t;
endpackage

// File: rtl/queue_ctrl_skid_buf2.sv
// skid_buf2: two-entry output FIFO holding RAM read data; head is the registered out_data
module skid_buf2 import queue_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          valid,
  output ob_cnt_t       cnt
);
  ob_cnt_t cnt_q, cnt_d;
  logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
  // head only changes when popped or when filling an empty buffer, keeping out_data stable under stall
  always_comb begin
    cnt_d = cnt_q + ob_cnt_t'(wr_en) - ob_cnt_t'(rd_en);
    e0_d = rd_en ? (cnt_q == 2'd2 ? e1_q : wr_data) : ((cnt_q == 2'd0 && wr_en) ? wr_data : e0_q);
    e1_d = (wr_en && (rd_en ? cnt_q == 2'd2 : cnt_q == 2'd1)) ? wr_data : e1_q;
  end
  always_ff @(posedge clk) begin
    cnt_q <= !rst_n ? '0 : cnt_d;
    e0_q <= e0_d;
    e1_q <= e1_d;
  end
  assign rd_data = e0_q;
  assign valid = cnt_q != 2'd0;
  assign cnt = cnt_q;
endmodule

// File: rtl/queue_ctrl.sv
// queue_ctrl: FIFO controller for an external 8x8 registered-read RAM with a 2-entry output buffer
module queue_ctrl import queue_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output occ_t          count,
  output logic          full,
  output logic          empty
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  occ_t ram_cnt_q, ram_cnt_d, count_q, count_d;
  logic inflight_q, inflight_d;
  logic push, pop, issue;
  ob_cnt_t ob_cnt;
  assign full = count_q == occ_t'(DEPTH);
  assign empty = count_q == '0;
  assign in_ready = !full;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  // issue only when the buffer plus the pending read leaves room after this cycle's pop
  assign issue = (ram_cnt_q != '0) && (({1'b0, ob_cnt} + {2'b0, inflight_q}) <= (3'd1 + {2'b0, pop}));
  assign mem_we = push;
  assign mem_waddr = wr_ptr_q;
  assign mem_wdata = in_data;
  assign mem_raddr = rd_ptr_q;
  assign count = count_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(issue);
    ram_cnt_d = ram_cnt_q + occ_t'(push) - occ_t'(issue);
    count_d = count_q + occ_t'(push) - occ_t'(pop);
    inflight_d = issue;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ram_cnt_q <= '0;
      count_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
    end
  end
  skid_buf2 #(.DW(DW)) u_ob (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(inflight_q),
    .wr_data(mem_rdata),
    .rd_en(pop),
    .rd_data(out_data),
    .valid(out_valid),
    .cnt(ob_cnt)
  );
endmodule

// File: tb/tb_queue_ctrl.sv
// tb_queue_ctrl: scoreboard bench for queue_ctrl with a behavioural 8x8 registered-read RAM
module tb_queue_ctrl;
  import queue_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, out_ready = 1'b0;
  logic [7:0] out_data;
  logic mem_we;
  logic [2:0] mem_waddr, mem_raddr;
  logic [7:0] mem_wdata, mem_rdata;
  occ_t count;
  logic full, empty;
  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  int nchk = 0, nerr = 0, npop = 0, npush = 0, mcnt = 0;
  logic hold = 1'b0;
  logic [7:0] held;

  queue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mcnt = 0;
      npush = 0;
      hold = 1'b0;
    end else begin
      chk("count", count, mcnt);
      chk("full", full, mcnt == 8);
      chk("empty", empty, mcnt == 0);
      chk("in_ready", in_ready, mcnt != 8);
      if (hold) chk("stable", out_data, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_underflow", exp_q.size(), 1);
        else chk("data", out_data, exp_q.pop_front());
        npop++;
        mcnt--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        npush++;
        mcnt++;
      end
      hold = out_valid && !out_ready;
      held = out_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    cyc();
  endtask

  task automatic first_word(input string tag, input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_wdata"}, mem_wdata, d);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_ov_t1"}, out_valid, 0);
    cyc();
    @(negedge clk);
    chk({tag, "_ov_t2"}, out_valid, 0);
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_ov_t3"}, out_valid, 1);
    chk({tag, "_data_t3"}, out_data, d);
    chk({tag, "_count_t3"}, count, 1);
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_ov_done"}, out_valid, 0);
    cyc();
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = base + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int n_exp);
    int p0;
    p0 = npop;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (empty) break;
      cyc();
    end
    chk({tag, "_drained"}, empty, 1);
    chk({tag, "_npop"}, npop - p0, n_exp);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int first, last, base, nxt, p0;
    do_reset();
    first_word("lat", 8'hA5);

    fill(8'h01, 8);
    in_valid = 1'b1;
    in_data = 8'h09;
    @(negedge clk);
    chk("full_flag", full, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_no_we", mem_we, 0);
    cyc();
    @(negedge clk);
    chk("full_no_we2", mem_we, 0);
    cyc();
    drain("d8", 8);

    fill(8'h31, 8);
    cyc();
    cyc();
    in_valid = 1'b1;
    in_data = 8'h39;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fp_in_ready", in_ready, 0);
    chk("fp_no_we", mem_we, 0);
    chk("fp_ov", out_valid, 1);
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("fp_count7", count, 7);
    chk("fp_we", mem_we, 1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("fp_count8", count, 8);
    cyc();
    drain("fp", 8);

    base = npush % 8;
    first = -1;
    last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid = c < 32;
      in_data = 8'(c);
      @(negedge clk);
      if (c < 32) chk("stream_waddr", mem_waddr, (base + c) % 8);
      if (out_valid && out_ready) begin
        if (first < 0) first = c;
        last = c;
      end
      cyc();
    end
    chk("stream_first", first, 3);
    chk("stream_last", last, 34);
    chk("stream_empty", empty, 1);
    chk("stream_sb", exp_q.size(), 0);

    nxt = 8'h10;
    p0 = npop;
    for (int c = 0; c < 600; c++) begin
      in_valid = (nxt <= 8'h2F) && ($urandom_range(0, 3) != 0);
      in_data = nxt[7:0];
      out_ready = $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (in_valid && in_ready) nxt++;
      if (nxt > 8'h2F && empty) break;
      cyc();
    end
    chk("rand_done", empty, 1);
    chk("rand_npop", npop - p0, 32);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;

    fill(8'h50, 5);
    cyc();
    cyc();
    cyc();
    in_valid = 1'b1;
    in_data = 8'h55;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pr_ov", out_valid, 1);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("pr_count5", count, 5);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("pr_count0", count, 0);
    chk("pr_ov0", out_valid, 0);
    chk("pr_empty", empty, 1);
    cyc();
    first_word("pr", 8'h77);
    chk("final_sb", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/queue_ctrl.md
QUEUE_CTRL -- requirements
Module: queue_ctrl

Interface
REQ-001 Parameters SHALL be: DW, 8, data width; AW, 3, RAM address width; DEPTH, 8, total item capacity (2**AW).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  producer offers in_data.
REQ-005 in_data  input  DW  write byte.
REQ-006 in_ready  output  1  controller accepts this cycle; push = in_valid && in_ready.
REQ-007 out_valid  output  1  out_data holds oldest item.
REQ-008 out_data  output  DW  read byte, registered.
REQ-009 out_ready  input  1  consumer takes item; pop = out_valid && out_ready.
REQ-010 mem_we  output  1  RAM write enable, equals push.
REQ-011 mem_waddr  output  AW  RAM write address, equals wr_ptr.
REQ-012 mem_wdata  output  DW  RAM write data, equals in_data.
REQ-013 mem_raddr  output  AW  RAM read address, equals rd_ptr.
REQ-014 mem_rdata  input  DW  RAM registered read data, valid one cycle after mem_raddr is sampled.
REQ-015 count  output  AW+1  total items held (RAM + in-flight + output buffer), 0..DEPTH.
REQ-016 full  output  1  count == DEPTH.
REQ-017 empty  output  1  count == 0.

Function
REQ-018 RAM side SHALL behave as 8x8 synchronous RAM: write on push edge, read registered with 1-cycle latency, read-before-write on address collision.
REQ-019 in_ready SHALL be !full, registered-state only; no combinational path from out_ready or pop.
REQ-020 Push SHALL write in_data at wr_ptr, then increment wr_ptr modulo 8 (7 -> 0 wrap).
REQ-021 ram_cnt (0..8) SHALL count items written but not yet read-issued: +1 on push, -1 on issue.
REQ-022 Output buffer SHALL be a 2-entry FIFO (ob_cnt 0..2); out_data/out_valid SHALL present its head.
REQ-023 Issue SHALL occur when ram_cnt != 0 and (ob_cnt + inflight - pop) <= 1; issue samples mem[rd_ptr], increments rd_ptr modulo 8, sets inflight for next cycle.
REQ-024 When inflight is set, mem_rdata SHALL be written into the output buffer that cycle; inflight clears unless a new issue occurs.
REQ-025 count SHALL be +1 on push, -1 on pop, unchanged on simultaneous push and pop.
REQ-026 First-word latency: push in cycle t -> out_valid high in cycle t+3 (t+1 issue, t+2 capture).
REQ-027 Throughput: with in_valid and out_ready held high, steady state SHALL be one push and one pop per cycle.
REQ-028 Order SHALL be strict FIFO; no item dropped or duplicated across pointer wrap.
REQ-029 At full, push SHALL NOT occur even if pop in same cycle; at empty, no bypass from in_data to out_data.
REQ-030 out_data SHALL stay stable while out_valid && !out_ready.

Reset
REQ-031 rst_n low at a clock edge SHALL clear wr_ptr, rd_ptr, ram_cnt, ob_cnt, inflight; count=0, empty=1, full=0, in_ready=1, out_valid=0, mem_we=0.
REQ-032 Reset mid-operation SHALL discard all held and in-flight items; RAM contents are not cleared and never read before being rewritten.
REQ-033 out_data value under reset is don't-care; out_valid governs.

Structure
REQ-034 DW, AW, DEPTH defaults and the occupancy-count type SHALL live in a shared package queue_pkg.
REQ-035 queue_ctrl SHALL NOT instantiate the RAM; the parent wires mem_* to the 8x8 RAM; the output buffer MAY be sub-module skid_buf2.

Verification
REQ-036 Reset, then push 0xA5 at cycle 0 -> out_valid at cycle 3, out_data=0xA5, count=1 -> pop -> empty=1.
REQ-037 out_ready=0, push 0x01..0x08 -> full=1, in_ready=0 after 8th; 9th offer 0x09 not accepted; drain yields 0x01..0x08.
REQ-038 Continuous stream 0x00..0x1F, in_valid=out_ready=1 -> all 32 bytes in order, one per cycle after 3-cycle fill, pointers wrap 4 times.
REQ-039 At full, in_valid=1 and out_ready=1 same cycle -> pop only, count 8->7, push accepted next cycle.
REQ-040 Random out_ready stalls with 0x10..0x2F -> out_data stable during stall, strict order, count matches scoreboard.
REQ-041 Reset asserted with count=5 and inflight=1 -> next cycle count=0, out_valid=0; new push 0x77 emerges alone at t+3.
